// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants, the stage-1 record and helpers for the DVI TMDS channel encoder.
package tmds_pkg;

  localparam int DISP_W = 5;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  // Everything stage 2 needs from stage 1, registered as one record.
  typedef struct packed {
    logic       blank;
    logic [1:0] c;
    logic [8:0] q_m;
    logic [3:0] n1;
    logic [3:0] n0;
  } qm_stage_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_C00;
      2'b01:   t = TOKEN_C01;
      2'b10:   t = TOKEN_C10;
      default: t = TOKEN_C11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// tmds_qm_stage: first pipeline stage, turns a pixel byte into the transition-minimised q_m word.
module tmds_qm_stage
  import tmds_pkg::*;
#(
  parameter logic [1:0] C_ctrl_reset = 2'b00
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       clk_pixel_ena,
  input  logic [7:0] i_data,
  input  logic [1:0] i_c,
  input  logic       i_blank,
  output logic       o_blank,
  output logic [1:0] o_c,
  output logic [8:0] o_q_m,
  output logic [3:0] o_n1,
  output logic [3:0] o_n0
);

  qm_stage_t  stage_d;
  qm_stage_t  stage_q;
  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m;

  // Pick XOR or XNOR chaining to minimise transitions, then count the ones left in q_m.
  always_comb begin
    n1d      = popcount8(i_data);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);
    q_m      = 9'd0;
    q_m[0]   = i_data[0];
    for (int i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ i_data[i]) : (q_m[i-1] ^ i_data[i]);
    end
    q_m[8]        = ~use_xnor;
    stage_d.blank = i_blank;
    stage_d.c     = i_c;
    stage_d.q_m   = q_m;
    stage_d.n1    = popcount8(q_m[7:0]);
    stage_d.n0    = 4'd8 - stage_d.n1;
  end

  // Stage-1 register: reset parks the pipe in a control period, otherwise advance on enable.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      stage_q.blank <= 1'b1;
      stage_q.c     <= C_ctrl_reset;
      stage_q.q_m   <= 9'd0;
      stage_q.n1    <= 4'd0;
      stage_q.n0    <= 4'd8;
    end else if (clk_pixel_ena) begin
      stage_q <= stage_d;
    end
  end

  assign o_blank = stage_q.blank;
  assign o_c     = stage_q.c;
  assign o_q_m   = stage_q.q_m;
  assign o_n1    = stage_q.n1;
  assign o_n0    = stage_q.n0;

endmodule

// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe: two-stage DVI TMDS encoder for one colour channel, with running DC balance.
module tmds_encoder_pipe
  import tmds_pkg::*;
#(
  parameter logic [1:0] C_ctrl_reset = 2'b00
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       clk_pixel_ena,
  input  logic [7:0] i_data,
  input  logic [1:0] i_c,
  input  logic       i_blank,
  output logic [9:0] o_tmds
);

  localparam logic signed [DISP_W-1:0] CNT_ZERO = 5'sd0;
  localparam logic signed [DISP_W-1:0] CNT_TWO  = 5'sd2;

  logic                     s1_blank;
  logic [1:0]               s1_c;
  logic [8:0]               s1_q_m;
  logic [3:0]               s1_n1;
  logic [3:0]               s1_n0;
  logic [9:0]               tmds_d;
  logic [9:0]               tmds_q;
  logic signed [DISP_W-1:0] cnt_d;
  logic signed [DISP_W-1:0] cnt_q;
  logic signed [DISP_W-1:0] diff;
  logic                     cnt_zero;
  logic                     cnt_pos;
  logic                     cnt_neg;

  tmds_qm_stage #(
    .C_ctrl_reset (C_ctrl_reset)
  ) u_qm_stage (
    .clk_pixel     (clk_pixel),
    .reset         (reset),
    .clk_pixel_ena (clk_pixel_ena),
    .i_data        (i_data),
    .i_c           (i_c),
    .i_blank       (i_blank),
    .o_blank       (s1_blank),
    .o_c           (s1_c),
    .o_q_m         (s1_q_m),
    .o_n1          (s1_n1),
    .o_n0          (s1_n0)
  );

  // Choose whether to invert q_m from the running disparity, and track the resulting balance.
  always_comb begin
    tmds_d   = tmds_q;
    cnt_d    = cnt_q;
    diff     = $signed({1'b0, s1_n1}) - $signed({1'b0, s1_n0});
    cnt_zero = (cnt_q == CNT_ZERO);
    cnt_neg  = cnt_q[DISP_W-1];
    cnt_pos  = !cnt_zero && !cnt_neg;
    if (s1_blank) begin
      tmds_d = ctrl_token(s1_c);
      cnt_d  = CNT_ZERO;
    end else if (cnt_zero || (s1_n1 == s1_n0)) begin
      tmds_d = {~s1_q_m[8], s1_q_m[8], s1_q_m[8] ? s1_q_m[7:0] : ~s1_q_m[7:0]};
      cnt_d  = s1_q_m[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && (s1_n1 > s1_n0)) || (cnt_neg && (s1_n0 > s1_n1))) begin
      tmds_d = {1'b1, s1_q_m[8], ~s1_q_m[7:0]};
      cnt_d  = cnt_q - diff + (s1_q_m[8] ? CNT_TWO : CNT_ZERO);
    end else begin
      tmds_d = {1'b0, s1_q_m[8], s1_q_m[7:0]};
      cnt_d  = cnt_q + diff - (s1_q_m[8] ? CNT_ZERO : CNT_TWO);
    end
  end

  // Output symbol and disparity counter; reset emits the idle control token whatever the enable.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds_q <= ctrl_token(C_ctrl_reset);
      cnt_q  <= CNT_ZERO;
    end else if (clk_pixel_ena) begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb_tmds_encoder_pipe: directed and randomized checks of the TMDS encoder against a behavioural model.
module tb_tmds_encoder_pipe;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic       clk_pixel_ena;
  logic [7:0] i_data;
  logic [1:0] i_c;
  logic       i_blank;
  logic [9:0] o_tmds;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: what sits in stage 1 (raw byte) and what is on the output.
  logic       m_blank;
  logic [1:0] m_c;
  logic [7:0] m_data;
  logic [9:0] m_out;
  int         m_cnt;
  logic       m_out_data;
  logic [7:0] m_out_byte;

  always #5 clk_pixel = ~clk_pixel;

  tmds_encoder_pipe #(
    .C_ctrl_reset (2'b00)
  ) dut (
    .clk_pixel     (clk_pixel),
    .reset         (reset),
    .clk_pixel_ena (clk_pixel_ena),
    .i_data        (i_data),
    .i_c           (i_c),
    .i_blank       (i_blank),
    .o_tmds        (o_tmds)
  );

  function automatic int ones(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [9:0] token(input logic [1:0] cc);
    case (cc)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference encoding: minimise transitions, then invert when that pulls the line back to balance.
  function automatic logic [9:0] model_encode(input logic [7:0] d, input int cnt_in);
    int         nd;
    int         n1;
    int         n0;
    logic [8:0] qm;
    logic       inv;
    nd    = ones({2'b00, d});
    qm    = 9'd0;
    qm[8] = !((nd > 4) || (nd == 4 && d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[8] ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    n1 = ones({2'b00, qm[7:0]});
    n0 = 8 - n1;
    if (cnt_in == 0 || n1 == n0) inv = ~qm[8];
    else inv = (cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1);
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w;
    logic [7:0] d;
    w    = s[9] ? ~s[7:0] : s[7:0];
    d    = 8'd0;
    d[0] = w[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return d;
  endfunction

  function automatic int dut_cnt();
    return int'($signed(dut.cnt_q));
  endfunction

  // One clock: drive inputs after the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic r, input logic en, input logic bl, input logic [1:0] cc,
                       input logic [7:0] d);
    logic [9:0] sym;
    reset = r; clk_pixel_ena = en; i_blank = bl; i_c = cc; i_data = d;
    @(posedge clk_pixel);
    if (r) begin
      m_blank = 1'b1; m_c = 2'b00; m_data = 8'h00;
      m_out = token(2'b00); m_cnt = 0; m_out_data = 1'b0;
    end else if (en) begin
      if (m_blank) begin
        m_out = token(m_c); m_cnt = 0; m_out_data = 1'b0;
      end else begin
        sym = model_encode(m_data, m_cnt);
        m_out = sym;
        m_cnt = m_cnt + 2 * ones(sym) - 10;
        m_out_data = 1'b1;
        m_out_byte = m_data;
      end
      m_blank = bl; m_c = cc; m_data = d;
    end
    @(negedge clk_pixel);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 8'hA5);
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 8'hA5);
    n_checks++;
    if (o_tmds !== 10'b1101010100) begin n_fail++; $display("[TB] FAIL reset_sym_noena: got %b expected %b", o_tmds, 10'b1101010100); end
    n_checks++;
    if (dut_cnt() !== 0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d expected 0", dut_cnt()); end
    cycle(1'b1, 1'b1, 1'b0, 2'b01, 8'h3C);
    n_checks++;
    if (o_tmds !== 10'b1101010100) begin n_fail++; $display("[TB] FAIL reset_sym_ena: got %b expected %b", o_tmds, 10'b1101010100); end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 2'b00, 8'h00);
      n_checks++;
      if (o_tmds !== 10'b1101010100) begin n_fail++; $display("[TB] FAIL post_reset_idle: got %b expected %b", o_tmds, 10'b1101010100); end
    end
  endtask

  task automatic test_control_tokens();
    logic [9:0] exp_tok [4];
    logic [9:0] prev;
    logic [1:0] cc;
    exp_tok[0] = 10'b1101010100; exp_tok[1] = 10'b0010101011;
    exp_tok[2] = 10'b0101010100; exp_tok[3] = 10'b1010101011;
    prev = 10'b1101010100;
    for (int k = 0; k < 4; k++) begin
      cc = 2'(k);
      cycle(1'b0, 1'b1, 1'b1, cc, 8'($urandom));
      n_checks++;
      if (o_tmds !== prev) begin n_fail++; $display("[TB] FAIL ctrl_latency c=%0d: got %b expected %b", k, o_tmds, prev); end
      cycle(1'b0, 1'b1, 1'b1, cc, 8'($urandom));
      n_checks++;
      if (o_tmds !== exp_tok[k]) begin n_fail++; $display("[TB] FAIL ctrl_token c=%0d: got %b expected %b", k, o_tmds, exp_tok[k]); end
      prev = exp_tok[k];
    end
  endtask

  task automatic test_zero_run_with_stall();
    logic [9:0] exp_sym [5];
    int         exp_cnt [5];
    exp_sym[0] = 10'b1010101011; exp_cnt[0] = 0;
    exp_sym[1] = 10'h100;        exp_cnt[1] = -8;
    exp_sym[2] = 10'h3FF;        exp_cnt[2] = 2;
    exp_sym[3] = 10'h100;        exp_cnt[3] = -6;
    exp_sym[4] = 10'h354;        exp_cnt[4] = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) cycle(1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
      else cycle(1'b0, 1'b1, 1'b1, 2'b00, 8'h00);
      n_checks++;
      if (o_tmds !== exp_sym[k]) begin n_fail++; $display("[TB] FAIL zero_run_sym%0d: got %h expected %h", k, o_tmds, exp_sym[k]); end
      n_checks++;
      if (dut_cnt() !== exp_cnt[k]) begin n_fail++; $display("[TB] FAIL zero_run_cnt%0d: got %0d expected %0d", k, dut_cnt(), exp_cnt[k]); end
      if (k == 2) begin
        for (int s = 0; s < 5; s++) begin
          cycle(1'b0, 1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
          n_checks++;
          if (o_tmds !== 10'h3FF) begin n_fail++; $display("[TB] FAIL stall_sym%0d: got %h expected %h", s, o_tmds, 10'h3FF); end
          n_checks++;
          if (dut_cnt() !== 2) begin n_fail++; $display("[TB] FAIL stall_cnt%0d: got %0d expected 2", s, dut_cnt()); end
        end
      end
    end
  endtask

  task automatic test_all_ones();
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 8'hFF);
    n_checks++;
    if (o_tmds !== 10'h354) begin n_fail++; $display("[TB] FAIL ones_lead: got %h expected %h", o_tmds, 10'h354); end
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 8'h00);
    n_checks++;
    if (o_tmds !== 10'h200) begin n_fail++; $display("[TB] FAIL ones_sym: got %h expected %h", o_tmds, 10'h200); end
    n_checks++;
    if (dut_cnt() !== -8) begin n_fail++; $display("[TB] FAIL ones_cnt: got %0d expected -8", dut_cnt()); end
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 8'h00);
    n_checks++;
    if (dut_cnt() !== 0) begin n_fail++; $display("[TB] FAIL ones_cnt_clear: got %0d expected 0", dut_cnt()); end
  endtask

  task automatic test_blank_restart();
    logic [9:0] exp_sym [5];
    logic       bl_seq  [5];
    exp_sym[0] = 10'h354; exp_sym[1] = 10'h100; exp_sym[2] = 10'h354;
    exp_sym[3] = 10'h100; exp_sym[4] = 10'h354;
    bl_seq[0] = 1'b0; bl_seq[1] = 1'b1; bl_seq[2] = 1'b0; bl_seq[3] = 1'b1; bl_seq[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, bl_seq[k], 2'b00, 8'h00);
      n_checks++;
      if (o_tmds !== exp_sym[k]) begin n_fail++; $display("[TB] FAIL blank_restart_sym%0d: got %h expected %h", k, o_tmds, exp_sym[k]); end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    n_checks++;
    if (o_tmds !== 10'h100) begin n_fail++; $display("[TB] FAIL mid_pre: got %h expected %h", o_tmds, 10'h100); end
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 8'hFF);
    n_checks++;
    if (o_tmds !== 10'h354 || dut_cnt() !== 0) begin n_fail++; $display("[TB] FAIL mid_reset: got %h/%0d expected %h/0", o_tmds, dut_cnt(), 10'h354); end
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 8'h12);
    n_checks++;
    if (o_tmds !== 10'h354) begin n_fail++; $display("[TB] FAIL mid_discard: got %h expected %h", o_tmds, 10'h354); end
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 8'h34);
    n_checks++;
    if (o_tmds !== m_out) begin n_fail++; $display("[TB] FAIL mid_first_sym: got %h expected %h", o_tmds, m_out); end
    n_checks++;
    if (decode(o_tmds) !== 8'h12) begin n_fail++; $display("[TB] FAIL mid_first_decode: got %h expected %h", decode(o_tmds), 8'h12); end
  endtask

  task automatic test_random();
    int c_now;
    for (int k = 0; k < 12000; k++) begin
      cycle(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 2'($urandom), 8'($urandom));
      c_now = dut_cnt();
      n_checks++;
      if (o_tmds !== m_out) begin n_fail++; if (n_fail < 20) $display("[TB] FAIL rand_sym @%0d: got %h expected %h", k, o_tmds, m_out); end
      n_checks++;
      if (c_now !== m_cnt) begin n_fail++; if (n_fail < 20) $display("[TB] FAIL rand_cnt @%0d: got %0d expected %0d", k, c_now, m_cnt); end
      n_checks++;
      if (c_now > 10 || c_now < -10) begin n_fail++; if (n_fail < 20) $display("[TB] FAIL rand_cnt_range @%0d: got %0d expected within +-10", k, c_now); end
      if (m_out_data) begin
        n_checks++;
        if (decode(o_tmds) !== m_out_byte) begin n_fail++; if (n_fail < 20) $display("[TB] FAIL rand_decode @%0d: got %h expected %h", k, decode(o_tmds), m_out_byte); end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset = 1'b0; clk_pixel_ena = 1'b0; i_blank = 1'b1; i_c = 2'b00; i_data = 8'h00;
    @(negedge clk_pixel);
    test_reset();
    test_control_tokens();
    test_zero_run_with_stall();
    test_all_ones();
    test_blank_restart();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
